// File: rtl/ip_sdram_arbiter_pkg.sv
// rtl/ip_sdram_arbiter_pkg.sv - shared types and constants for the SDRAM front-end arbiter
package ip_sdram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ip_sdram_arbiter_grant.sv
// rtl/ip_sdram_arbiter_grant.sv - combinational round-robin / fixed-priority channel picker
module ip_sdram_arbiter_grant #(
    parameter int CH = 3,
    parameter int IW = $clog2(CH)
) (
    input  logic [CH-1:0] req_i,
    input  logic [IW-1:0] rr_last_i,
    input  logic          mode_i,
    output logic [IW-1:0] grant_o,
    output logic          any_req_o
);

    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        grant_o   = '0;
        any_req_o = |req_i;
        sel       = '0;
        found     = 1'b0;
        if (mode_i) begin
            // Descending scan so the lowest requesting index is the last write.
            for (int i = CH - 1; i >= 0; i--) begin
                if (req_i[IW'(i)]) grant_o = IW'(i);
            end
        end else begin
            for (int i = 1; i <= CH; i++) begin
                sel = IW'((int'(rr_last_i) + i) % CH);
                if (!found && req_i[sel]) begin
                    grant_o = sel;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ip_sdram_arbiter.sv
// rtl/ip_sdram_arbiter.sv - time-shares one SDRAM byte port among CH requesters
module ip_sdram_arbiter
    import ip_sdram_arbiter_pkg::*;
#(
    parameter int CH        = 3,
    parameter int AW        = 23,
    parameter int DW        = 8,
    parameter int PRIO_MODE = 0,
    parameter int HOLD      = 4,
    parameter int WR_GAP    = 12,
    parameter int RD_GAP    = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CH-1:0]    ch_req,
    input  logic [CH-1:0]    ch_wr,
    input  logic [CH*AW-1:0] ch_address,
    input  logic [CH*DW-1:0] ch_wdata,
    output logic [CH-1:0]    ch_ack,
    output logic [DW-1:0]    ch_rdata,
    output logic [CH-1:0]    ch_rdata_en,
    output logic             timeout_err,
    input  logic             sdram_busy,
    output logic             merq_n,
    output logic             rd_n,
    output logic             wr_n,
    output logic [AW-1:0]    address,
    output logic [DW-1:0]    wdata,
    input  logic [DW-1:0]    rdata,
    input  logic             rdata_en
);

    localparam int IW = $clog2(CH);
    localparam int CW = $clog2(max4(HOLD, WR_GAP, RD_GAP, TIMEOUT)) + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_last_q, rr_last_d;
    logic          is_wr_q, is_wr_d;
    logic          merq_n_q, merq_n_d;
    logic          rd_n_q, rd_n_d;
    logic          wr_n_q, wr_n_d;
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CH-1:0] ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CH-1:0] rdata_en_q, rdata_en_d;
    logic          timeout_q, timeout_d;

    logic [IW-1:0] pick;
    logic          any_req;

    ip_sdram_arbiter_grant #(
        .CH (CH),
        .IW (IW)
    ) u_grant (
        .req_i     (ch_req),
        .rr_last_i (rr_last_q),
        .mode_i    (PRIO_MODE == PRIO_FIXED),
        .grant_o   (pick),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        is_wr_d    = is_wr_q;
        merq_n_d   = merq_n_q;
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        address_d  = address_q;
        wdata_d    = wdata_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        rdata_en_d = '0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!sdram_busy && any_req) begin
                    grant_d = pick;
                    if (PRIO_MODE == PRIO_RR) rr_last_d = pick;
                    // Constant-index mux keeps the channel slices free of variable part-selects.
                    for (int i = 0; i < CH; i++) begin
                        if (pick == IW'(i)) begin
                            is_wr_d   = ch_wr[i];
                            address_d = ch_address[i*AW +: AW];
                            wdata_d   = ch_wdata[i*DW +: DW];
                            rd_n_d    = ch_wr[i];
                            wr_n_d    = !ch_wr[i];
                            ack_d[i]  = 1'b1;
                        end
                    end
                    merq_n_d = 1'b0;
                    cnt_d    = CW'(HOLD - 1);
                    state_d  = ISSUE;
                end
            end

            ISSUE: begin
                if (cnt_q == '0) begin
                    merq_n_d  = 1'b1;
                    rd_n_d    = 1'b1;
                    wr_n_d    = 1'b1;
                    address_d = '0;
                    wdata_d   = '0;
                    if (is_wr_q) begin
                        cnt_d   = CW'(WR_GAP - 1);
                        state_d = RECOVER;
                    end else begin
                        cnt_d   = CW'(TIMEOUT - 1);
                        state_d = WAIT_RD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            WAIT_RD: begin
                if (rdata_en || cnt_q == '0) begin
                    // A lost read still completes to its owner, with zero data and an error flag.
                    rdata_d   = rdata_en ? rdata : '0;
                    timeout_d = !rdata_en;
                    for (int i = 0; i < CH; i++) begin
                        if (grant_q == IW'(i)) rdata_en_d[i] = 1'b1;
                    end
                    cnt_d   = CW'(RD_GAP - 1);
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            rr_last_q  <= IW'(CH - 1);
            is_wr_q    <= 1'b0;
            merq_n_q   <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            address_q  <= '0;
            wdata_q    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            rdata_en_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            is_wr_q    <= is_wr_d;
            merq_n_q   <= merq_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            rdata_en_q <= rdata_en_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ch_ack      = ack_q;
    assign ch_rdata    = rdata_q;
    assign ch_rdata_en = rdata_en_q;
    assign timeout_err = timeout_q;
    assign merq_n      = merq_n_q;
    assign rd_n        = rd_n_q;
    assign wr_n        = wr_n_q;
    assign address     = address_q;
    assign wdata       = wdata_q;

endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// tb/tb_ip_sdram_arbiter.sv - directed self-checking bench for ip_sdram_arbiter
module tb_ip_sdram_arbiter;

    localparam int CH = 3;
    localparam int AW = 23;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [CH-1:0]    ch_req = '0;
    logic [CH-1:0]    ch_wr = '0;
    logic [CH*AW-1:0] ch_address = '0;
    logic [CH*DW-1:0] ch_wdata = '0;
    logic             sdram_busy = 1'b0;
    logic [DW-1:0]    rdata = '0;
    logic             rdata_en = 1'b0;

    logic [CH-1:0]    ch_ack, ch_rdata_en;
    logic [DW-1:0]    ch_rdata, wdata;
    logic             timeout_err, merq_n, rd_n, wr_n;
    logic [AW-1:0]    address;

    logic [CH-1:0]    f_ch_ack, f_ch_rdata_en;
    logic [DW-1:0]    f_ch_rdata, f_wdata;
    logic             f_timeout_err, f_merq_n, f_rd_n, f_wr_n;
    logic [AW-1:0]    f_address;
    logic [DW-1:0]    f_rdata = '0;
    logic             f_rdata_en = 1'b0;

    int tests_run = 0;
    int errors    = 0;

    always #5 clk = ~clk;

    ip_sdram_arbiter #(.CH(CH), .AW(AW), .DW(DW), .PRIO_MODE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_wr(ch_wr),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_ack(ch_ack),
        .ch_rdata(ch_rdata), .ch_rdata_en(ch_rdata_en), .timeout_err(timeout_err),
        .sdram_busy(sdram_busy), .merq_n(merq_n), .rd_n(rd_n), .wr_n(wr_n),
        .address(address), .wdata(wdata), .rdata(rdata), .rdata_en(rdata_en)
    );

    ip_sdram_arbiter #(.CH(CH), .AW(AW), .DW(DW), .PRIO_MODE(1)) u_dut_fixed (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_wr(ch_wr),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_ack(f_ch_ack),
        .ch_rdata(f_ch_rdata), .ch_rdata_en(f_ch_rdata_en), .timeout_err(f_timeout_err),
        .sdram_busy(sdram_busy), .merq_n(f_merq_n), .rd_n(f_rd_n), .wr_n(f_wr_n),
        .address(f_address), .wdata(f_wdata), .rdata(f_rdata), .rdata_en(f_rdata_en)
    );

    // Byte-wide memory model: read data returns a fixed latency after the command starts.
    logic [DW-1:0] mem [0:7];
    logic          no_rd = 1'b0;
    logic          merq_prev = 1'b1;
    int            lat = 0;
    logic [2:0]    rd_addr = '0;

    always @(posedge clk) begin
        rdata_en  <= 1'b0;
        merq_prev <= merq_n;
        if (merq_prev && !merq_n) begin
            if (!wr_n) mem[address[2:0]] <= wdata;
            if (!rd_n) begin
                lat     <= 5;
                rd_addr <= address[2:0];
            end
        end else if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1 && !no_rd) begin
                rdata_en <= 1'b1;
                rdata    <= mem[rd_addr];
            end
        end
    end

    task automatic set_ch(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_wr[ch]              = wr;
        ch_address[ch*AW +: AW] = a;
        ch_wdata[ch*DW +: DW]   = d;
    endtask

    // kind 0 waits for ch_ack[ch], kind 1 for ch_rdata_en[ch]
    task automatic wait_sig(input int kind, input int ch, input int limit, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (kind == 0 && ch_ack[ch]) ok = 1'b1;
            if (kind == 1 && ch_rdata_en[ch]) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        ch_req     = '0;
        sdram_busy = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({merq_n, rd_n, wr_n} !== 3'b111) begin errors++; $display("FAIL reset_cmd: got %b expected 111", {merq_n, rd_n, wr_n}); end
        tests_run++;
        if (address !== '0 || wdata !== '0) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", address, wdata); end
        tests_run++;
        if (ch_ack !== '0 || ch_rdata_en !== '0) begin errors++; $display("FAIL reset_pulses: got %b/%b expected 000/000", ch_ack, ch_rdata_en); end
        tests_run++;
        if (ch_rdata !== '0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_rdata: got %h/%b expected 00/0", ch_rdata, timeout_err); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        bit ok;
        int cyc, lowcnt, hicnt, extra;
        set_ch(0, 1'b1, 23'h000003, 8'h45);
        ch_req[0] = 1'b1;
        wait_sig(0, 0, 50, ok, cyc);
        tests_run++;
        if (!ok) begin errors++; $display("FAIL wr_ack: got none expected ch_ack[0] within 50 cycles"); end
        tests_run++;
        if ({merq_n, rd_n, wr_n} !== 3'b010 || address !== 23'h3 || wdata !== 8'h45)
            begin errors++; $display("FAIL wr_cmd: got %b %h %h expected 010 000003 45", {merq_n, rd_n, wr_n}, address, wdata); end
        lowcnt = 1;
        extra  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ch_ack != '0) extra++;
            if (merq_n !== 1'b0) break;
            lowcnt++;
        end
        tests_run++;
        if (lowcnt != 4) begin errors++; $display("FAIL wr_hold: got %0d expected 4", lowcnt); end
        tests_run++;
        if (extra != 0) begin errors++; $display("FAIL wr_ack_once: got %0d extra acks expected 0", extra); end
        tests_run++;
        if (wr_n !== 1'b1 || address !== '0 || wdata !== '0) begin errors++; $display("FAIL wr_release: got %b %h %h expected 1 0 0", wr_n, address, wdata); end
        hicnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (merq_n === 1'b0) break;
            hicnt++;
        end
        tests_run++;
        if (hicnt != 13) begin errors++; $display("FAIL wr_gap: got %0d expected 13", hicnt); end
        tests_run++;
        if (ch_ack !== 3'b001) begin errors++; $display("FAIL wr_second_ack: got %b expected 001", ch_ack); end
        ch_req = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_write_readback();
        bit ok;
        int cyc;
        logic [DW-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 8'h12 + 8'(i * 17);
            set_ch(1, 1'b1, 23'(i), v);
            ch_req[1] = 1'b1;
            wait_sig(0, 1, 60, ok, cyc);
            ch_req[1] = 1'b0;
            tests_run++;
            if (!ok) begin errors++; $display("FAIL wb_wr_ack[%0d]: got none expected ack", i); end
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            v = 8'h12 + 8'(i * 17);
            set_ch(2, 1'b0, 23'(i), 8'h00);
            ch_req[2] = 1'b1;
            wait_sig(0, 2, 60, ok, cyc);
            ch_req[2] = 1'b0;
            if (ok) wait_sig(1, 2, 100, ok, cyc);
            tests_run++;
            if (!ok || ch_rdata !== v) begin errors++; $display("FAIL wb_rd[%0d]: got %h ok=%0d expected %h", i, ch_rdata, ok, v); end
            tests_run++;
            if (ch_rdata_en[1:0] !== 2'b00 || timeout_err !== 1'b0)
                begin errors++; $display("FAIL wb_rd_other[%0d]: got %b/%b expected 00/0", i, ch_rdata_en[1:0], timeout_err); end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        no_rd = 1'b1;
        set_ch(0, 1'b0, 23'h000005, 8'h00);
        ch_req[0] = 1'b1;
        wait_sig(0, 0, 60, ok, cyc);
        ch_req[0] = 1'b0;
        wait_sig(1, 0, 200, ok, cyc);
        tests_run++;
        if (!ok || cyc != 68) begin errors++; $display("FAIL to_latency: got %0d ok=%0d expected 68", cyc, ok); end
        tests_run++;
        if (timeout_err !== 1'b1 || ch_rdata !== 8'h00 || ch_rdata_en !== 3'b001)
            begin errors++; $display("FAIL to_pulse: got err=%b rdata=%h en=%b expected 1 00 001", timeout_err, ch_rdata, ch_rdata_en); end
        set_ch(1, 1'b1, 23'h000006, 8'h5a);
        ch_req[1] = 1'b1;
        @(negedge clk);
        tests_run++;
        if (timeout_err !== 1'b0 || ch_rdata_en !== '0) begin errors++; $display("FAIL to_one_cycle: got %b/%b expected 0/000", timeout_err, ch_rdata_en); end
        wait_sig(0, 1, 60, ok, cyc);
        ch_req[1] = 1'b0;
        tests_run++;
        if (!ok || cyc != 16) begin errors++; $display("FAIL to_back_to_idle: got %0d ok=%0d expected 16", cyc, ok); end
        no_rd = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int order [0:3];
        int n, f_ch0, f_other, idx;
        do_reset();
        for (int i = 0; i < CH; i++) set_ch(i, 1'b0, 23'(i), 8'h00);
        ch_req  = 3'b111;
        n       = 0;
        f_ch0   = 0;
        f_other = 0;
        for (int c = 0; c < 400 && n < 4; c++) begin
            @(negedge clk);
            if (f_ch_ack[0]) f_ch0++;
            if (f_ch_ack[2:1] != 2'b00) f_other++;
            if (ch_ack != '0) begin
                tests_run++;
                if (!$onehot(ch_ack)) begin errors++; $display("FAIL rr_onehot: got %b expected one-hot", ch_ack); end
                idx = 0;
                for (int i = 0; i < CH; i++) if (ch_ack[i]) idx = i;
                order[n] = idx;
                n++;
            end
        end
        ch_req = '0;
        tests_run++;
        if (n != 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", n); end
        else begin
            tests_run++;
            if (order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 0)
                begin errors++; $display("FAIL rr_order: got %0d %0d %0d %0d expected 0 1 2 0", order[0], order[1], order[2], order[3]); end
        end
        tests_run++;
        if (f_ch0 == 0 || f_other != 0) begin errors++; $display("FAIL fixed_prio: got ch0=%0d others=%0d expected >0 and 0", f_ch0, f_other); end
    endtask

    task automatic test_busy();
        int acks, lows;
        do_reset();
        sdram_busy = 1'b1;
        set_ch(0, 1'b1, 23'h000001, 8'hc3);
        ch_req[0] = 1'b1;
        acks = 0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ch_ack != '0) acks++;
            if (merq_n !== 1'b1) lows++;
        end
        tests_run++;
        if (acks != 0 || lows != 0) begin errors++; $display("FAIL busy_block: got acks=%0d lows=%0d expected 0 0", acks, lows); end
        sdram_busy = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ch_ack !== 3'b001 || merq_n !== 1'b0) begin errors++; $display("FAIL busy_release: got ack=%b merq_n=%b expected 001 0", ch_ack, merq_n); end
        ch_req = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        set_ch(0, 1'b1, 23'h000002, 8'h77);
        ch_req[0] = 1'b1;
        wait_sig(0, 0, 60, ok, cyc);
        ch_req[0] = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        tests_run++;
        if (merq_n !== 1'b1 || wr_n !== 1'b1 || address !== '0) begin errors++; $display("FAIL async_reset: got %b %b %h expected 1 1 0", merq_n, wr_n, address); end
        @(negedge clk);
        reset_n = 1'b1;
        set_ch(0, 1'b1, 23'h000004, 8'h3c);
        ch_req[0] = 1'b1;
        wait_sig(0, 0, 60, ok, cyc);
        ch_req[0] = 1'b0;
        tests_run++;
        if (!ok || cyc != 1) begin errors++; $display("FAIL post_reset_ack: got %0d ok=%0d expected 1", cyc, ok); end
        tests_run++;
        if (wr_n !== 1'b0 || address !== 23'h4 || wdata !== 8'h3c) begin errors++; $display("FAIL post_reset_cmd: got %b %h %h expected 0 000004 3c", wr_n, address, wdata); end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_readback();
        test_timeout();
        test_round_robin();
        test_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

endmodule
